core_stream_adapter: RTL and testbench
======================================

CORE_STREAM_ADAPTER -- requirements
Module: core_stream_adapter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter NUM_PIXELS, default 784, pixels per frame (>=2).
REQ-003 SHALL have parameter DIGIT_WIDTH, default 4, classification result width.
REQ-004 SHALL have parameter RESULT_DEPTH, default 4, result queue entries and maximum frames in flight (power of 2, >=2).
REQ-005 SHALL have ports:
  clk  in  1  sole clock, rising edge;
  rst  in  1  asynchronous, active-high reset;
  s_valid  in  1  upstream pixel valid;
  s_ready  out  1  adapter accepts pixel;
  s_pixel  in  DATA_WIDTH  upstream pixel;
  core_i_valid  out  1  pixel strobe to core;
  core_pixel  out  DATA_WIDTH  pixel to core;
  core_o_valid  in  1  core result strobe;
  core_digit  in  DIGIT_WIDTH  core result;
  m_valid  out  1  result available;
  m_ready  in  1  downstream accepts result;
  m_digit  out  DIGIT_WIDTH  result at queue head;
  err_overflow  out  1  sticky, unsolicited core result dropped.

Function
REQ-006 SHALL transfer a pixel on a cycle when s_valid && s_ready; SHALL transfer a result on a cycle when m_valid && m_ready.
REQ-007 SHALL implement FSM IDLE/STREAM; IDLE->STREAM on the first accepted pixel of a frame; STREAM->IDLE on acceptance of pixel NUM_PIXELS.
REQ-008 SHALL reserve one credit at frame start (IDLE acceptance) and release it on each result pop; credits range 0..RESULT_DEPTH.
REQ-009 SHALL drive s_ready = (state==STREAM) || (state==IDLE && credits>0); once a frame starts it SHALL never be refused admission mid-frame for credit reasons.
REQ-010 SHALL register each accepted pixel: core_i_valid and core_pixel valid exactly 1 cycle after acceptance; core_pixel holds its value when core_i_valid=0.
REQ-011 SHALL count pixels 0..NUM_PIXELS-1 within a frame and wrap to 0 at frame end.
REQ-012 SHALL push core_digit into the result queue on core_o_valid when not full; if full, SHALL drop it and set err_overflow.
REQ-013 SHALL present the queue head on m_digit with m_valid=!empty; m_digit stable while m_valid && !m_ready.
REQ-014 Simultaneous push and pop on a full queue SHALL both succeed (no drop); on an empty queue the push SHALL occur and m_valid assert next cycle.
REQ-015 Simultaneous frame start and pop with credits=0 SHALL NOT admit that cycle (s_ready from registered credits); admission allowed next cycle.

Reset
REQ-016 On rst SHALL asynchronously force: state=IDLE, pixel count=0, credits=RESULT_DEPTH, queue empty, s_ready=1, core_i_valid=0, core_pixel=0, m_valid=0, m_digit=0, err_overflow=0.
REQ-017 Reset mid-frame SHALL discard the partial frame and all queued results; no core_i_valid pulse after reset assertion.

Configuration
REQ-018 Macro CORE_STREAM_FRAME_CHECK_EN SHALL, when defined, add port s_last (in, 1) and sticky output err_frame (out, 1, reset 0).
REQ-019 With the macro, err_frame SHALL set when an accepted pixel has s_last mismatching (count==NUM_PIXELS-1); framing still follows count only.
REQ-020 Without the macro, s_last and err_frame SHALL not exist and framing SHALL be by count alone.

Structure
REQ-021 Shared package core_stream_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-022 Result queue SHALL be sub-module core_result_fifo (parametrised width/depth, registered head, full/empty).

Verification
REQ-023 Reset then 784 pixels 0..783 back-to-back: core_i_valid high 784 cycles, starting 1 cycle after first acceptance; core_pixel mirrors input.
REQ-024 Four frames with m_ready=0 and core result 4'd7 per frame: fifth frame's first pixel sees s_ready=0; one pop -> s_ready=1 next cycle, m_digit=7.
REQ-025 Queue full (4 entries), core_o_valid and m_ready=1 same cycle: occupancy stays 4, err_overflow=0.
REQ-026 Queue full, m_ready=0, extra core_o_valid with 4'd3: entry dropped, err_overflow=1 until reset.
REQ-027 Assert rst after pixel 300: s_ready=1, m_valid=0, credits=4; next frame counts from pixel 0.
REQ-028 With CORE_STREAM_FRAME_CHECK_EN, s_last on pixel 500: err_frame=1; framing ends at pixel 784.

Source files
------------

// File: rtl/core_stream_pkg.sv
// Shared types and default parameters for the core stream adapter.
package core_stream_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_NUM_PIXELS   = 784;
  localparam int DEF_DIGIT_WIDTH  = 4;
  localparam int DEF_RESULT_DEPTH = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } stream_state_e;

endpackage

// File: rtl/core_result_fifo.sv
// Result queue: flop-based FIFO whose head is always visible on o_data.
// A push into a full queue succeeds only when a pop happens in the same cycle.
module core_result_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [AW-1:0]               r_wr;
  logic [AW-1:0]               r_rd;
  logic [AW:0]                 r_cnt;
  logic                        w_push;
  logic                        w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_data  = r_mem[r_rd];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop)
        r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/core_stream_adapter.sv
// Streams pixel frames into a classifier core and queues its results, with
// credit-based frame admission. CORE_STREAM_FRAME_CHECK_EN adds s_last/err_frame.
module core_stream_adapter
  import core_stream_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int NUM_PIXELS   = DEF_NUM_PIXELS,
  parameter int DIGIT_WIDTH  = DEF_DIGIT_WIDTH,
  parameter int RESULT_DEPTH = DEF_RESULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_WIDTH-1:0]  s_pixel,
  output logic                   core_i_valid,
  output logic [DATA_WIDTH-1:0]  core_pixel,
  input  logic                   core_o_valid,
  input  logic [DIGIT_WIDTH-1:0] core_digit,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DIGIT_WIDTH-1:0] m_digit,
  output logic                   err_overflow
`ifdef CORE_STREAM_FRAME_CHECK_EN
  ,
  input  logic                   s_last,
  output logic                   err_frame
`endif
);

  localparam int CW = $clog2(RESULT_DEPTH + 1);
  localparam int PW = $clog2(NUM_PIXELS);
  localparam logic [CW-1:0] CRED_MAX = CW'(RESULT_DEPTH);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_PIXELS - 1);

  stream_state_e   r_state;
  stream_state_e   w_state_nxt;
  logic [PW-1:0]   r_count;
  logic [CW-1:0]   r_credits;
  logic [CW-1:0]   w_credits_nxt;
  logic            w_accept;
  logic            w_start;
  logic            w_last;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;

  assign w_accept = s_valid && s_ready;
  assign w_start  = w_accept && (r_state == ST_IDLE);
  assign w_last   = (r_count == LAST_IDX);
  assign m_valid  = !w_empty;
  assign w_pop    = m_valid && m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Admission depends only on registered state, so a pop can never open the
  // door in the same cycle it happens.
  always_comb begin
    w_state_nxt = r_state;
    s_ready     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        s_ready = (r_credits != '0);
        if (s_valid && s_ready) w_state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        s_ready = 1'b1;
        if (s_valid && w_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_count <= '0;
    else if (w_accept) r_count <= w_last ? '0 : r_count + PW'(1);
  end

  // Unsolicited results can be popped too; saturate rather than overshoot.
  always_comb begin
    w_credits_nxt = r_credits;
    if (w_start && !w_pop)
      w_credits_nxt = r_credits - CW'(1);
    else if (!w_start && w_pop && (r_credits != CRED_MAX))
      w_credits_nxt = r_credits + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_credits <= CRED_MAX;
    else     r_credits <= w_credits_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_i_valid <= 1'b0;
      core_pixel   <= '0;
    end else begin
      core_i_valid <= w_accept;
      if (w_accept) core_pixel <= s_pixel;
    end
  end

  core_result_fifo #(
    .WIDTH (DIGIT_WIDTH),
    .DEPTH (RESULT_DEPTH)
  ) u_result_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (core_o_valid),
    .i_data  (core_digit),
    .i_pop   (m_ready),
    .o_data  (m_digit),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  err_overflow <= 1'b0;
    else if (core_o_valid && w_full && !w_pop) err_overflow <= 1'b1;
  end

`ifdef CORE_STREAM_FRAME_CHECK_EN
  // Framing stays count-driven; s_last only feeds the sticky diagnostic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               err_frame <= 1'b0;
    else if (w_accept && (s_last != w_last)) err_frame <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_core_stream_adapter.sv
// Scoreboard bench for core_stream_adapter: directed frame scenarios plus a
// random phase, checked against a queue-based behavioural model.
module tb_core_stream_adapter;

  localparam int DW    = 8;
  localparam int NP    = 784;
  localparam int GW    = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_pixel = '0;
  logic          s_last = 1'b0;
  logic          core_i_valid;
  logic [DW-1:0] core_pixel;
  logic          core_o_valid = 1'b0;
  logic [GW-1:0] core_digit = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [GW-1:0] m_digit;
  logic          err_overflow;
`ifdef CORE_STREAM_FRAME_CHECK_EN
  logic          err_frame;
`endif

  core_stream_adapter #(
    .DATA_WIDTH(DW), .NUM_PIXELS(NP), .DIGIT_WIDTH(GW), .RESULT_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel),
    .core_i_valid(core_i_valid), .core_pixel(core_pixel),
    .core_o_valid(core_o_valid), .core_digit(core_digit),
    .m_valid(m_valid), .m_ready(m_ready), .m_digit(m_digit),
    .err_overflow(err_overflow)
`ifdef CORE_STREAM_FRAME_CHECK_EN
    , .s_last(s_last), .err_frame(err_frame)
`endif
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int n_civ = 0;

  // Behavioural model: pixels in the current frame, frames in flight, queues.
  logic [DW-1:0] pixq[$];
  logic [GW-1:0] rq[$];
  int            m_pix = 0;
  int            m_cred = DEPTH;
  bit            m_errov = 0;
  bit            m_errf = 0;
  logic [DW-1:0] last_px = '0;
  bit            inj_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit exp_sready();
    return (m_pix != 0) || (m_cred > 0);
  endfunction

  always @(posedge clk) begin : model
    bit acc, pop;
    if (!rst) begin
      acc = s_valid && exp_sready();
      pop = m_ready && (rq.size() != 0);
      if (acc) begin
        if (s_last != (m_pix == NP - 1)) m_errf = 1;
        if (m_pix == 0) m_cred--;
        pixq.push_back(s_pixel);
        m_pix = (m_pix == NP - 1) ? 0 : m_pix + 1;
      end
      if (pop) begin
        void'(rq.pop_front());
        if (m_cred < DEPTH) m_cred++;
      end
      if (core_o_valid) begin
        if (rq.size() < DEPTH) rq.push_back(core_digit);
        else m_errov = 1;
      end
    end
  end

  always @(negedge clk) begin : monitor
    bit exp_civ;
    exp_civ = (pixq.size() != 0);
    chk("s_ready", 32'(s_ready), 32'(exp_sready()));
    chk("m_valid", 32'(m_valid), 32'(rq.size() != 0));
    if (rq.size() != 0) chk("m_digit", 32'(m_digit), 32'(rq[0]));
    chk("err_overflow", 32'(err_overflow), 32'(m_errov));
`ifdef CORE_STREAM_FRAME_CHECK_EN
    chk("err_frame", 32'(err_frame), 32'(m_errf));
`endif
    chk("core_i_valid", 32'(core_i_valid), 32'(exp_civ));
    if (core_i_valid) n_civ++;
    if (exp_civ) last_px = pixq.pop_front();
    chk("core_pixel", 32'(core_pixel), 32'(last_px));
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set(input bit sv, input int px, input bit mr, input bit cov, input int dg);
    s_valid      = sv;
    s_pixel      = DW'(px);
    m_ready      = mr;
    core_o_valid = cov;
    core_digit   = GW'(dg);
    s_last       = (m_pix == NP - 1) ^ (inj_en && m_pix == 500);
  endtask

  // One full frame, then optionally one core result (dg < 0 means none).
  task automatic frame(input int dg);
    for (int i = 0; i < NP; i++) begin
      step();
      set(1, i, 0, 0, 0);
    end
    step();
    set(0, 0, 0, dg >= 0, (dg >= 0) ? dg : 0);
    step();
    set(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    set(0, 0, 0, 0, 0);
    pixq.delete();
    rq.delete();
    m_pix = 0; m_cred = DEPTH; m_errov = 0; m_errf = 0; last_px = '0;
    step();
    step();
    chk("rst s_ready", 32'(s_ready), 32'd1);
    chk("rst m_valid", 32'(m_valid), 32'd0);
    chk("rst m_digit", 32'(m_digit), 32'd0);
    chk("rst core_i_valid", 32'(core_i_valid), 32'd0);
    chk("rst err_overflow", 32'(err_overflow), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    repeat (3) step();
    chk("rst s_ready", 32'(s_ready), 32'd1);
    chk("rst m_valid", 32'(m_valid), 32'd0);
    chk("rst m_digit", 32'(m_digit), 32'd0);
    chk("rst core_pixel", 32'(core_pixel), 32'd0);
    chk("rst err_overflow", 32'(err_overflow), 32'd0);
    rst = 1'b0;

    // Back-to-back frame with a bad s_last on pixel 500, then three more.
    inj_en = 1;
    frame(7);
    inj_en = 0;
    chk("civ count frame1", 32'(n_civ), 32'(NP));
    frame(7);
    frame(7);
    frame(7);

    // Credits exhausted: a fifth frame is refused until a pop.
    step();
    set(1, 0, 0, 0, 0);
    step();
    chk("s_ready no credit", 32'(s_ready), 32'd0);
    chk("head before pop", 32'(m_digit), 32'd7);
    set(0, 0, 1, 0, 0);
    step();
    chk("s_ready after pop", 32'(s_ready), 32'd1);
    set(0, 0, 0, 1, 9);

    // Full queue with simultaneous push and pop: nothing dropped.
    step();
    chk("queue full", 32'(rq.size()), 32'(DEPTH));
    set(0, 0, 1, 1, 5);
    step();
    chk("no overflow push+pop", 32'(err_overflow), 32'd0);
    set(0, 0, 0, 1, 3);
    step();
    set(0, 0, 0, 0, 0);
    step();
    chk("overflow on drop", 32'(err_overflow), 32'd1);
    set(0, 0, 1, 0, 0);
    repeat (6) step();
    chk("overflow sticky", 32'(err_overflow), 32'd1);
    set(0, 0, 0, 0, 0);

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      step();
      set($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)), $urandom_range(0, 1) == 1,
          $urandom_range(0, 99) == 0, int'($urandom_range(0, 15)));
    end

    // Mid-frame reset, then four frames from a clean start.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step();
      set(1, i, 0, 0, 0);
    end
    do_reset();
    n_civ = 0;
    frame(-1);
    frame(-1);
    frame(-1);
    frame(-1);
    chk("civ count 4 frames", 32'(n_civ), 32'(4 * NP));
    step();
    set(1, 0, 0, 0, 0);
    step();
    chk("s_ready after 4 frames", 32'(s_ready), 32'd0);
    set(0, 0, 0, 0, 0);
    step();
    step();
    chk("pixel queue drained", 32'(pixq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
